param_divider: RTL and testbench

//  Parametrised multi-cycle radix-2 restoring divider; successor to the fixed 16-bit unsigned divider.

---
 rtl/param_divider.sv | 178 +++++++++++++++++
 tb/tb_param_divider.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_divider.sv
// Multi-cycle radix-2 restoring divider with optional signed mode.
// One quotient bit per clock, MSB first; signs are applied in a single
// fix-up cycle so the iteration core only ever sees magnitudes.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | out of reset, waiting for start
// CALC  | WIDTH shift/subtract iterations on the magnitudes
// FIX   | sign correction, result/flag write, done asserted next
// DONE  | result held, start accepted again (back-to-back capable)
//
// A zero divisor skips CALC and goes straight to the write-back cycle.
// The result write is shared with the normal path, so the dbz result
// appears one clock after the accepting edge.
module param_divider #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};

    state_t           state;
    state_t           state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] a_raw;
    logic             neg_q;
    logic             neg_r;
    logic             dbz_pend;
    logic             ovf_pend;

    logic             accept;
    logic             use_signed;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH+1:0] trial;
    logic             take;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             unused_trial_bit;

    assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
    assign use_signed = SIGNED_EN && signed_op;

    // Magnitudes: MIN negates to itself, which is exactly 2^(WIDTH-1)
    // when read as unsigned, so no extra bit is needed here.
    assign mag_a = (use_signed && A[WIDTH-1]) ? -A : A;
    assign mag_b = (use_signed && B[WIDTH-1]) ? -B : B;

    // Shift {rem,quo} left by one and try to subtract the divisor.
    // rem < dvs holds between iterations, so the shifted remainder fits
    // WIDTH+1 bits and any kept result fits back into WIDTH bits.
    assign rem_sh = {rem, quo[WIDTH-1]};
    assign quo_sh = {quo[WIDTH-2:0], 1'b0};
    assign trial  = {1'b0, rem_sh} - {2'b00, dvs};
    assign take   = ~trial[WIDTH+1];

    // trial[WIDTH] is always zero whenever the subtraction is kept.
    assign unused_trial_bit = trial[WIDTH];

    assign q_fix = neg_q ? -quo : quo;
    assign r_fix = neg_r ? -rem : rem;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (B == '0) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == LAST_ITER) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration datapath and result/flag write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            a_raw    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dbz_pend <= 1'b0;
            ovf_pend <= 1'b0;
            Q        <= '0;
            R        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= mag_a;
            dvs      <= mag_b;
            a_raw    <= A;
            neg_q    <= use_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_r    <= use_signed && A[WIDTH-1];
            dbz_pend <= (B == '0);
            ovf_pend <= use_signed && (A == MIN_VAL) && (B == ALL_ONES);
            busy     <= 1'b1;
            done     <= 1'b0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
        end else if (state == S_CALC) begin
            cnt <= cnt + CNT_W'(1);
            rem <= take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo <= {quo_sh[WIDTH-1:1], take};
        end else if (state == S_FIX) begin
            // MIN/-1 needs no special case: the magnitude quotient is
            // 2^(WIDTH-1) with equal signs, which already reads as MIN.
            if (dbz_pend) begin
                Q <= ALL_ONES;
                R <= a_raw;
            end else begin
                Q <= q_fix;
                R <= r_fix;
            end
            dbz  <= dbz_pend;
            ovf  <= ovf_pend;
            busy <= 1'b0;
            done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_param_divider.sv
// Bench for param_divider: a 16-bit signed-capable instance and an 8-bit
// unsigned-only instance, checked against integer / and % reference results.
module tb_param_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] Q;
    logic [15:0] R;
    logic        busy, done, dbz, ovf;

    logic        start8 = 1'b0;
    logic        signed_op8 = 1'b0;
    logic [7:0]  A8 = '0;
    logic [7:0]  B8 = '0;
    logic [7:0]  Q8;
    logic [7:0]  R8;
    logic        busy8, done8, dbz8, ovf8;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] prev_q = '0;
    logic [15:0] prev_r = '0;

    param_divider #(.WIDTH(16), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .A(A), .B(B), .Q(Q), .R(R),
        .busy(busy), .done(done), .dbz(dbz), .ovf(ovf)
    );

    param_divider #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_op(signed_op8),
        .A(A8), .B(B8), .Q(Q8), .R(R8),
        .busy(busy8), .done(done8), .dbz(dbz8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Truncating division as plain integer arithmetic.
    function automatic void model16(input logic [15:0] a, input logic [15:0] b, input bit s,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output bit dz, output bit ov);
        int sa;
        int sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 16'd0) begin
            q  = 16'hFFFF;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -32768 && sb == -1) begin
                q  = 16'h8000;
                r  = 16'h0000;
                ov = 1'b1;
            end else begin
                q = 16'(sa / sb);
                r = 16'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // One full operation on the 16-bit unit. ign>0 re-asserts start at
    // edge E<ign> (while busy) with junk operands that must be ignored.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit s, input int ign);
        logic [15:0] eq, er;
        bit          edz, eov;
        int          cyc;
        int          exp_lat;
        bit          stable;
        bit          excl;
        model16(a, b, s, eq, er, edz, eov);
        exp_lat = (b == 16'd0) ? 1 : 17;
        @(negedge clk);
        start = 1'b1; A = a; B = b; signed_op = s;
        @(posedge clk); #1;
        check("e0_busy", 32'(busy), 32'd1);
        check("e0_flags_clear", 32'({done, dbz, ovf}), 32'd0);
        cyc = 0; stable = 1'b1; excl = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            start     = (ign > 0 && cyc == ign - 1);
            A         = 16'($urandom);
            B         = 16'($urandom);
            signed_op = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
            if (busy && done) excl = 1'b0;
            if (!done && (Q !== prev_q || R !== prev_r)) stable = 1'b0;
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        check("quotient", 32'(Q), 32'(eq));
        check("remainder", 32'(R), 32'(er));
        check("dbz", 32'(dbz), 32'(edz));
        check("ovf", 32'(ovf), 32'(eov));
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("qr_stable_while_busy", 32'(stable), 32'd1);
        check("busy_done_exclusive", 32'(excl), 32'd1);
        prev_q = eq;
        prev_r = er;
    endtask

    // 8-bit unsigned-only unit; signed_op is driven randomly and must be ignored.
    task automatic do_op8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] eq, er;
        bit         edz;
        int         cyc;
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; edz = 1'b1;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0;
        end
        @(negedge clk);
        start8 = 1'b1; A8 = a; B8 = b; signed_op8 = 1'($urandom);
        @(posedge clk); #1;
        cyc = 0;
        while (!done8 && cyc < 30) begin
            @(negedge clk);
            start8 = 1'b0; A8 = 8'($urandom); B8 = 8'($urandom); signed_op8 = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        check("w8_latency", 32'(cyc), (b == 8'd0) ? 32'd1 : 32'd9);
        check("w8_quotient", 32'(Q8), 32'(eq));
        check("w8_remainder", 32'(R8), 32'(er));
        check("w8_flags", 32'({dbz8, ovf8}), 32'({edz, 1'b0}));
    endtask

    initial begin
        logic [15:0] ra, rb;
        bit          rs;
        int          sel;

        #12;
        check("rst_q_r", 32'({Q, R}), 32'd0);
        check("rst_ctrl", 32'({busy, done, dbz, ovf}), 32'd0);
        check("rst_w8", 32'({Q8, R8, busy8, done8, dbz8, ovf8}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start", 32'({busy, done}), 32'd0);

        do_op(16'd1000, 16'd7, 1'b0, 0);
        check("t1_q_142", 32'(Q), 32'd142);
        check("t1_r_6", 32'(R), 32'd6);

        do_op(16'hFFF9, 16'h0002, 1'b1, 0);
        check("t2_signed_q", 32'(Q), 32'h0000FFFD);
        check("t2_signed_r", 32'(R), 32'h0000FFFF);
        do_op(16'hFFF9, 16'h0002, 1'b0, 0);
        check("t2_unsigned_q", 32'(Q), 32'h00007FFC);
        check("t2_unsigned_r", 32'(R), 32'h00000001);

        do_op(16'd1234, 16'd0, 1'b0, 0);
        check("t3_dbz_q", 32'(Q), 32'h0000FFFF);
        check("t3_dbz_r", 32'(R), 32'd1234);
        do_op(16'd10, 16'd3, 1'b0, 0);
        check("t3_dbz_cleared", 32'({dbz, Q, R}), 32'({1'b0, 16'd3, 16'd1}));

        do_op(16'h8000, 16'hFFFF, 1'b1, 0);
        check("t4_ovf", 32'({ovf, Q, R}), 32'({1'b1, 16'h8000, 16'h0000}));
        do_op(16'h8000, 16'h0001, 1'b1, 0);
        check("t4_no_ovf", 32'({ovf, Q}), 32'({1'b0, 16'h8000}));
        do_op(16'h8000, 16'hFFFF, 1'b0, 0);
        check("t4_unsigned_no_ovf", 32'({ovf, Q, R}), 32'({1'b0, 16'h0000, 16'h8000}));

        do_op(16'd500, 16'd9, 1'b0, 5);
        check("t5_ignored_start", 32'({Q, R}), 32'({16'd55, 16'd5}));

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; A = 16'd1000; B = 16'd3; signed_op = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midop_rst_q_r", 32'({Q, R}), 32'd0);
        check("midop_rst_ctrl", 32'({busy, done, dbz, ovf}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_q = '0;
        prev_r = '0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 32'({busy, done, Q}), 32'd0);
        do_op(16'd10, 16'd3, 1'b1, 0);

        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 15);
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rs  = 1'($urandom);
            case (sel)
                0: rb = 16'd0;
                1: begin ra = 16'h8000; rb = 16'hFFFF; rs = 1'b1; end
                2: rb = 16'($urandom_range(1, 15));
                3: ra = 16'h8000;
                4: rb = 16'hFFFF;
                5: rb = 16'd1;
                default: ;
            endcase
            do_op(ra, rb, rs, 0);
        end

        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 9);
            do_op8(8'($urandom), (sel == 0) ? 8'd0 : 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
